// File: rtl/axi4_stream_pkg.sv
// Shared constants and types for the AXI4-Stream packetizer slice.
// Holds the FSM encoding, the stream data width and the all-bytes keep mask.
package axi4_stream_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  // A requested length of zero still produces single-beat packets.
  function automatic logic [15:0] eff_len(input logic [15:0] len);
    return (len == '0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/axi4_stream_packetizer_if.sv
// AXI4-Stream master-side bundle used on the packetizer output.
// Signal names follow the stream port names of the original block.
interface axi4_stream_packetizer_if
  import axi4_stream_pkg::*;
#(
  parameter int unsigned DATA_W = axi4_stream_pkg::DATA_W
);

  logic [DATA_W-1:0] M_TDATA;
  logic              M_TVALID;
  logic              M_TREADY;
  logic              M_TLAST;
  logic [KEEP_W-1:0] M_TKEEP;

  modport master (
    output M_TDATA,
    output M_TVALID,
    output M_TLAST,
    output M_TKEEP,
    input  M_TREADY
  );

  modport slave (
    input  M_TDATA,
    input  M_TVALID,
    input  M_TLAST,
    input  M_TKEEP,
    output M_TREADY
  );

endinterface

// File: rtl/axi4_stream_packetizer_fifo.sv
// Synchronous first-word-fall-through buffer with occupancy count.
// A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
module axi4_stream_packetizer_fifo #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned AW     = $clog2(DEPTH),
  localparam int unsigned CW     = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi4_stream_packetizer.sv
// Buffers a backpressure-free sample stream and emits it as fixed-length
// AXI4-Stream packets, with sticky overflow and a saturating drop counter.
module axi4_stream_packetizer
  import axi4_stream_pkg::*;
#(
  parameter  int unsigned DATA_W     = axi4_stream_pkg::DATA_W,
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     ACLK,
  input  logic                     RSTN,
  input  logic                     en,
  input  logic [DATA_W-1:0]        IN_TDATA,
  input  logic                     IN_VALID,
  input  logic [15:0]              pkt_len,
  input  logic                     clr_ovf,
  axi4_stream_packetizer_if.master m_axis,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [CW-1:0]            fill_level
);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       beat_q, beat_d;
  logic              ovf_q, ovf_d;
  logic [15:0]       drop_q, drop_d;

  logic              accept, push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head;
  logic              tvalid, tlast;
  logic [DATA_W-1:0] tdata;

  // Gating with RSTN keeps samples out of the buffer while reset is held.
  assign accept = RSTN && IN_VALID && en;
  assign pop    = tvalid && m_axis.M_TREADY;
  assign push   = accept && (!fifo_full || pop);
  assign drop   = accept && !push;

  axi4_stream_packetizer_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (ACLK),
    .rst_ni  (RSTN),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (IN_TDATA),
    .rdata_o (head),
    .count_o (fill_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tdata   = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          len_d   = eff_len(pkt_len);
          beat_d  = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        // An empty buffer only pauses the packet; framing state is kept.
        tvalid = !fifo_empty;
        tdata  = head;
        tlast  = (beat_q == (len_q - 16'd1));
        if (tvalid && m_axis.M_TREADY) begin
          beat_d = beat_q + 16'd1;
          if (tlast) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (clr_ovf) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    // A drop coinciding with a clear restarts the count at one.
    if (drop) begin
      ovf_d = 1'b1;
      if (clr_ovf)                drop_d = 16'd1;
      else if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      else                        drop_d = drop_q;
    end
  end

  always_ff @(posedge ACLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      len_q   <= 16'd1;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  assign m_axis.M_TDATA  = tdata;
  assign m_axis.M_TVALID = tvalid;
  assign m_axis.M_TLAST  = tlast;
  assign m_axis.M_TKEEP  = KEEP_ALL;
  assign overflow        = ovf_q;
  assign drop_cnt        = drop_q;

endmodule

// File: doc/axi4_stream_packetizer.md
AXI4_STREAM_PACKETIZER -- requirements
Module: axi4_stream_packetizer

Interface
REQ-001 Parameter DATA_W, 32, stream data width in bits; SHALL be 32 in this release.
REQ-002 Parameter FIFO_DEPTH, 16, entries in the input buffer; SHALL be a power of two, 4 to 256.
REQ-003 ACLK  in  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-004 RSTN  in  1  asynchronous, active-low reset.
REQ-005 en  in  1  input accept enable.
REQ-006 IN_TDATA  in  32  sample from the upstream data generator.
REQ-007 IN_VALID  in  1  sample qualifier; upstream has no backpressure.
REQ-008 pkt_len  in  16  beats per packet; 0 SHALL be treated as 1.
REQ-009 clr_ovf  in  1  clears overflow and drop_cnt.
REQ-010 M_TDATA  out  32  AXI4-Stream data.
REQ-011 M_TVALID  out  1  AXI4-Stream valid.
REQ-012 M_TREADY  in  1  AXI4-Stream ready.
REQ-013 M_TLAST  out  1  last beat of a packet.
REQ-014 M_TKEEP  out  4  SHALL be constant 4'hF.
REQ-015 overflow  out  1  sticky flag: a sample was dropped.
REQ-016 drop_cnt  out  16  dropped-sample count; saturates at 16'hFFFF.
REQ-017 fill_level  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-018 Push SHALL occur when IN_VALID && en && (fill_level<FIFO_DEPTH || pop in the same cycle).
REQ-019 IN_VALID && en && no push SHALL be a drop: overflow<=1, drop_cnt+1 (saturating).
REQ-020 IN_VALID with en=0 SHALL be ignored and SHALL NOT count as a drop.
REQ-021 clr_ovf SHALL clear overflow and drop_cnt; a drop in the same cycle SHALL win, leaving overflow=1 and drop_cnt=1.
REQ-022 The FSM SHALL have two states, IDLE and STREAM.
REQ-023 IDLE: M_TVALID=0; when fill_level!=0, latch len_q<=max(pkt_len,1), beat_cnt<=0, go to STREAM.
REQ-024 STREAM: M_TVALID=(fill_level!=0); M_TDATA=FIFO head; M_TLAST=(beat_cnt==len_q-1).
REQ-025 A handshake (M_TVALID&&M_TREADY) SHALL pop one entry and increment beat_cnt; on a handshake with M_TLAST=1 the FSM SHALL return to IDLE.
REQ-026 Latency: a sample pushed at edge k into an empty FIFO SHALL give M_TVALID after edge k+2 in IDLE, or after edge k+1 in STREAM.
REQ-027 One IDLE cycle SHALL separate consecutive packets.
REQ-028 While M_TVALID=1 and M_TREADY=0, M_TDATA and M_TLAST SHALL hold stable.
REQ-029 pkt_len changes SHALL affect only the next packet.
REQ-030 FIFO empty mid-packet: M_TVALID SHALL drop, with no packet termination.
REQ-031 en=0 mid-packet SHALL NOT truncate a packet; buffered data SHALL still drain.
REQ-032 Pointers SHALL wrap modulo FIFO_DEPTH; beat_cnt SHALL be 16 bits wide.

Reset
REQ-033 RSTN low SHALL asynchronously force: state=IDLE; FIFO empty; fill_level=0; M_TVALID=0, M_TLAST=0, M_TDATA=0; overflow=0; drop_cnt=0; beat_cnt=0; len_q=1.
REQ-034 Reset mid-packet SHALL discard buffered data; the first beat after reset SHALL start a new packet.
REQ-035 Reset deassertion SHALL take effect on the next ACLK edge; no push SHALL occur while RSTN=0.

Structure
REQ-036 Package axi4_stream_pkg SHALL hold the FSM state encodings, DATA_W, and the KEEP_ALL constant (4'hF).
REQ-037 The buffer SHALL be sub-module axi4_stream_packetizer_fifo: synchronous, first-word-fall-through, with push/pop/count ports.

Verification
REQ-038 pkt_len=4, M_TREADY=1, IN_VALID=1 with data 1..8 -> two packets 1-4 and 5-8, TLAST on 4 and 8, one IDLE cycle between them.
REQ-039 FIFO_DEPTH=16, M_TREADY=0, 20 samples -> fill_level=16, drop_cnt=4, overflow=1; then clr_ovf -> both 0.
REQ-040 M_TREADY toggling 1010..., pkt_len=3 -> M_TDATA/M_TLAST stable while stalled, TLAST every third accepted beat.
REQ-041 pkt_len=0 -> every beat has TLAST=1; changing pkt_len from 4 to 2 mid-packet -> current packet stays 4 beats, next is 2.
REQ-042 RSTN pulsed low after beat 2 of a 4-beat packet -> all outputs 0 immediately; next packet starts at beat 0 with fresh data.
REQ-043 Push and pop in the same cycle at fill_level=16 -> no drop, fill_level stays 16.
